pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter MDU_LAT, default 4, meaning EX-stage occupancy in cycles of a mul/div instruction (legal 2..16).
REQ-002 The block SHALL have one clock and asynchronous active-low reset: ports clk and rstn.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rstn  in  1  async active-low reset
- IF_ID_rs  in  5  rs of instruction in ID
- IF_ID_rt  in  5  rt of instruction in ID
- ID_EX_mem_read  in  1  instruction in EX is a load
- ID_EX_rt  in  5  load destination in EX
- ID_EX_mdu_op  in  1  instruction in EX is mul/div
- EX_branch_taken  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- id_ex_write  out  1  ID/EX register enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  clear ID/EX control to bubble
- ex_mem_flush  out  1  clear EX/MEM control to bubble
- mdu_start  out  1  one-cycle start pulse to multi-cycle unit
- mdu_done  out  1  final EX cycle of mul/div
- stall_count  out  32  cycles with pc_write=0
- flush_count  out  32  branch flushes issued

Function
REQ-004 FSM states SHALL be IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-005 In IDLE with ID_EX_mdu_op=1: mdu_start=1, mdu stall active, next state BUSY, cnt loaded with MDU_LAT-2.
REQ-006 In BUSY with cnt!=0: mdu stall active, cnt decrements, state stays BUSY.
REQ-007 In BUSY with cnt==0: mdu stall inactive, mdu_done=1, next state IDLE; ID_EX_mdu_op in this cycle SHALL NOT restart the unit.
REQ-008 Mdu stall SHALL therefore last exactly MDU_LAT-1 consecutive cycles; back-to-back mul/div ops restart from IDLE on the following cycle.
REQ-009 Mdu stall active: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1, if_id_flush=0, id_ex_flush=0.
REQ-010 Branch flush (EX_branch_taken=1, mdu stall inactive): if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1, id_ex_write=1.
REQ-011 Load-use: ID_EX_mem_read=1, ID_EX_rt!=0, ID_EX_rt equal to IF_ID_rs or IF_ID_rt -> pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, for exactly that cycle.
REQ-012 Priority SHALL be mdu stall > branch flush > load-use; lower-priority conditions are fully suppressed.
REQ-013 With no condition active: all write enables 1, all flushes 0, mdu_start=0, mdu_done=0.
REQ-014 All control outputs SHALL be combinational from current state, cnt and inputs; no added latency.
REQ-015 stall_count SHALL increment by 1 at each clock edge where pc_write=0, saturating at 32'hFFFF_FFFF.
REQ-016 flush_count SHALL increment by 1 at each clock edge where branch flush (REQ-010) is active, saturating at 32'hFFFF_FFFF.

Reset
REQ-017 rstn low SHALL asynchronously force state IDLE, cnt 0, stall_count 0, flush_count 0.
REQ-018 While rstn is low, outputs SHALL equal the REQ-013 idle values regardless of inputs; reset in BUSY aborts the op with no mdu_done.
REQ-019 After rstn deasserts, the first rising edge SHALL evaluate inputs normally.

Structure
REQ-020 State encodings (IDLE=1'b0, BUSY=1'b1) and MDU_LAT default SHALL reside in the shared pipeline header/package.
REQ-021 The occupancy counter SHALL be one sub-module, mdu_timer (load, decrement, zero flag); the rest SHALL be flat.

Verification
REQ-022 Load-use: lw $t0 in EX (ID_EX_mem_read=1, ID_EX_rt=8), IF_ID_rs=8 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1.
REQ-023 Load to $zero: ID_EX_rt=0, IF_ID_rs=0 -> no stall, stall_count unchanged.
REQ-024 MDU_LAT=4, ID_EX_mdu_op=1 at cycle T -> mdu_start at T only; stall T..T+2; mdu_done at T+3; stall_count=3.
REQ-025 Mdu stall with EX_branch_taken=1 and load-use true -> only mdu stall outputs; flush_count unchanged.
REQ-026 EX_branch_taken=1 and load-use true same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1, stall_count=0.
REQ-027 rstn low at T+1 during mdu op -> outputs idle immediately, counters 0, no mdu_done; next mdu op restarts at full MDU_LAT.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Definitions shared by the pipeline hazard controller and its mul/div
//   occupancy timer.
//   Contents:
//     state_t          IDLE / BUSY encoding of the mul/div occupancy FSM
//     MDU_LAT_DEFAULT  default EX-stage occupancy of a mul/div instruction
//     MDU_LAT_MIN/MAX  legal occupancy range
//     CNT_W            width of the occupancy down-counter
//     CNT_MAX          saturation value of the 32-bit event counters
//     mdu_load_value() counter preload for a given occupancy
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MDU_LAT_DEFAULT = 4;
  localparam int MDU_LAT_MIN     = 2;
  localparam int MDU_LAT_MAX     = 16;

  localparam int CNT_W = 4;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // The first occupancy cycle is spent in IDLE (the start cycle) and the
  // last one is the cnt==0 cycle in BUSY, so the counter is preloaded with
  // two less than the total occupancy.
  function automatic logic [CNT_W-1:0] mdu_load_value(input int lat);
    return CNT_W'(lat - 2);
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// ---------------------------------------------------------------------------
// mdu_timer
//   4-bit down-counter tracking how many EX cycles a mul/div instruction
//   still occupies.
//   Ports:
//     clk       in   clock, rising edge
//     rstn      in   asynchronous active-low reset (counter -> 0)
//     load      in   load load_val this cycle (takes priority over dec)
//     load_val  in   value to load
//     dec       in   decrement this cycle (ignored when already zero)
//     cnt       out  current count
//     zero      out  count is zero
// ---------------------------------------------------------------------------
module mdu_timer
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard controller for a classic 5-stage pipeline. Resolves, in priority
//   order, the multi-cycle mul/div stall, taken-branch flush and load-use
//   stall, and keeps saturating counts of stall cycles and branch flushes.
//   All pipeline control outputs are combinational from the FSM state, the
//   occupancy count and the current inputs.
//   Parameters:
//     MDU_LAT          EX occupancy of a mul/div instruction (2..16)
//   Ports:
//     clk              in   clock, rising edge
//     rstn             in   asynchronous active-low reset
//     IF_ID_rs/rt      in   source registers of the instruction in ID
//     ID_EX_mem_read   in   instruction in EX is a load
//     ID_EX_rt         in   load destination register in EX
//     ID_EX_mdu_op     in   instruction in EX is mul/div
//     EX_branch_taken  in   branch/jump in EX resolved taken
//     pc_write         out  PC update enable
//     if_id_write      out  IF/ID register enable
//     id_ex_write      out  ID/EX register enable
//     if_id_flush      out  clear IF/ID to NOP
//     id_ex_flush      out  clear ID/EX control to bubble
//     ex_mem_flush     out  clear EX/MEM control to bubble
//     mdu_start        out  one-cycle start pulse to the multi-cycle unit
//     mdu_done         out  final EX cycle of a mul/div
//     stall_count      out  saturating count of cycles with pc_write=0
//     flush_count      out  saturating count of branch flushes
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  ID_EX_rt,
  input  logic        ID_EX_mdu_op,
  input  logic        EX_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mdu_start,
  output logic        mdu_done,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam logic [CNT_W-1:0] LOAD_VAL = mdu_load_value(MDU_LAT);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             timer_dec;

  logic             mdu_stall;
  logic             branch_flush;
  logic             load_use_hit;
  logic             load_use_stall;

  logic [31:0]      stall_count_reg;
  logic [31:0]      flush_count_reg;

  // -------------------------------------------------------------------------
  // Occupancy counter
  // -------------------------------------------------------------------------
  assign timer_dec = (state_reg == BUSY) && !cnt_zero;

  mdu_timer u_mdu_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (mdu_start),
    .load_val (LOAD_VAL),
    .dec      (timer_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // -------------------------------------------------------------------------
  // Mul/div occupancy FSM. The done cycle always returns to IDLE, so a
  // mul/div seen during it is only picked up on the following cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (ID_EX_mdu_op) state_reg <= BUSY;
        BUSY:    if (cnt_zero)     state_reg <= IDLE;
        default:                   state_reg <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Hazard detection. Every condition is qualified with rstn so that the
  // outputs sit at their idle values for the whole reset, whatever the
  // inputs are doing.
  // -------------------------------------------------------------------------
  always_comb begin
    mdu_stall = 1'b0;
    mdu_start = 1'b0;
    mdu_done  = 1'b0;
    if (rstn) begin
      if (state_reg == IDLE) begin
        if (ID_EX_mdu_op) begin
          mdu_stall = 1'b1;
          mdu_start = 1'b1;
        end
      end else if (!cnt_zero) begin
        mdu_stall = 1'b1;
      end else begin
        mdu_done = 1'b1;
      end
    end
  end

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign load_use_hit = rstn && ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
                        ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));

  assign branch_flush   = rstn && EX_branch_taken && !mdu_stall;
  assign load_use_stall = load_use_hit && !mdu_stall && !EX_branch_taken;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (mdu_stall) begin
      // Freeze the front end and keep EX/MEM fed with bubbles while the
      // multi-cycle unit holds the EX stage.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (branch_flush) begin
      // The two younger instructions are on the wrong path.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use_stall) begin
      // Hold the dependent instruction in ID and insert one bubble into EX.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Saturating event counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (!pc_write && (stall_count_reg != CNT_MAX)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
      if (branch_flush && (flush_count_reg != CNT_MAX)) begin
        flush_count_reg <= flush_count_reg + 32'd1;
      end
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

endmodule
